alu_ctrl: RTL

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/alu_ctrl.sv
// Multi-cycle sequencer that fetches 9-bit instructions from a sync ROM and steers an external ALU/register file.
// Define SC_CHAIN_EN to feed the latched shift-carry flag back into the ALU during EXEC.
module alu_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [8:0] instr,
  input  logic       alu_zero,
  input  logic       alu_sc,
  output logic [7:0] prog_ctr,
  output logic [2:0] alu_cmd,
  output logic [1:0] ra_addr,
  output logic [1:0] rb_addr,
  output logic       alu_sc_i,
  output logic       reg_we,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [1:0] OP_BZ   = 2'b00;
  localparam logic [1:0] OP_JMP  = 2'b01;
  localparam logic [1:0] OP_HALT = 2'b10;

  state_t     state, next_state;
  logic [8:0] ir;
  logic       zero_flag;
  logic       is_ctrl;
  logic [1:0] subop;
  logic [7:0] offset_ext;
  logic       branch_taken;
  logic       is_halt;
  logic [7:0] pc_next;

`ifdef SC_CHAIN_EN
  logic       carry_flag;
`else
  logic       unused_sc;
  assign unused_sc = alu_sc;
`endif

  assign is_ctrl      = ir[8];
  assign subop        = ir[7:6];
  assign offset_ext   = {{2{ir[5]}}, ir[5:0]};
  assign branch_taken = is_ctrl && ((subop == OP_JMP) || ((subop == OP_BZ) && zero_flag));
  assign is_halt      = is_ctrl && (subop == OP_HALT);
  // Adds wrap naturally at 8 bits, giving modulo-256 program addressing.
  assign pc_next      = branch_taken ? (prog_ctr + offset_ext) : (prog_ctr + 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      prog_ctr  <= 8'd0;
      ir        <= 9'd0;
      zero_flag <= 1'b0;
`ifdef SC_CHAIN_EN
      carry_flag <= 1'b0;
`endif
    end else begin
      state <= next_state;
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            prog_ctr  <= 8'd0;
            zero_flag <= 1'b0;
`ifdef SC_CHAIN_EN
            carry_flag <= 1'b0;
`endif
          end
        end
        S_DECODE: ir <= instr;
        S_EXEC: begin
          if (!is_ctrl) begin
            zero_flag <= alu_zero;
`ifdef SC_CHAIN_EN
            carry_flag <= alu_sc;
`endif
          end
        end
        S_WB: begin
          if (!is_halt) prog_ctr <= pc_next;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    reg_we     = 1'b0;
    alu_cmd    = 3'd0;
    ra_addr    = 2'd0;
    rb_addr    = 2'd0;
    alu_sc_i   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_FETCH;
      end
      S_FETCH: begin
        busy       = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        busy       = 1'b1;
        next_state = S_EXEC;
      end
      S_EXEC: begin
        busy       = 1'b1;
        alu_cmd    = ir[7:5];
        ra_addr    = ir[4:3];
        rb_addr    = ir[2:1];
`ifdef SC_CHAIN_EN
        alu_sc_i   = carry_flag;
`endif
        next_state = S_WB;
      end
      S_WB: begin
        busy       = 1'b1;
        alu_cmd    = ir[7:5];
        ra_addr    = ir[4:3];
        rb_addr    = ir[2:1];
        reg_we     = !is_ctrl;
        next_state = is_halt ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        done = 1'b1;
        if (start) next_state = S_FETCH;
      end
      default: next_state = S_IDLE;
    endcase
  end

endmodule
